// File: rtl/udp_rx_unpack.sv
// Unpacks a UDP byte payload into DATA_W-bit user words, MSB-first, dropping frames not addressed to LOCAL_PORT.
// Optional UDP_RX_STATS_EN adds frame_cnt/drop_cnt counters and ports.
module udp_rx_unpack #(
    parameter int unsigned DATA_W     = 32,
    parameter logic [15:0] LOCAL_PORT = 16'd8080
) (
    input  logic              sys_clk,
    input  logic              sys_rstn,
    input  logic              s_udp_hdr_valid,
    output logic              s_udp_hdr_ready,
    input  logic [15:0]       s_udp_dest_port,
    input  logic [7:0]        s_udp_payload_axis_tdata,
    input  logic              s_udp_payload_axis_tvalid,
    output logic              s_udp_payload_axis_tready,
    input  logic              s_udp_payload_axis_tlast,
    input  logic              s_udp_payload_axis_tuser,
    output logic [DATA_W-1:0] dout_data,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              dout_err
`ifdef UDP_RX_STATS_EN
    ,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned K_W   = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  asm_q, asm_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               err_q, err_d;
    logic               hdr_ready_c;
    logic               tready_c;
    logic [DATA_W-1:0]  word_c;

    // Next-state, byte assembly and output register loading
    always_comb begin
        state_d     = state_q;
        asm_d       = asm_q;
        k_d         = k_q;
        data_d      = data_q;
        valid_d     = valid_q;
        last_d      = last_q;
        err_d       = err_q;
        hdr_ready_c = 1'b0;
        tready_c    = 1'b0;
        word_c      = asm_q;

        for (int unsigned b = 0; b < BYTES; b++) begin
            if (k_q == K_W'(b)) begin
                word_c[DATA_W-1-8*b -: 8] = s_udp_payload_axis_tdata;
            end
        end

        if (valid_q && dout_ready) begin
            data_d  = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            err_d   = 1'b0;
        end

        case (state_q)
            IDLE: begin
                hdr_ready_c = 1'b1;
                if (s_udp_hdr_valid) begin
                    state_d = (s_udp_dest_port == LOCAL_PORT) ? RECV : DROP;
                    asm_d   = '0;
                    k_d     = '0;
                end
            end
            RECV: begin
                tready_c = !valid_q || dout_ready;
                if (s_udp_payload_axis_tvalid && tready_c) begin
                    if ((k_q == K_W'(BYTES - 1)) || s_udp_payload_axis_tlast) begin
                        data_d  = word_c;
                        valid_d = 1'b1;
                        last_d  = s_udp_payload_axis_tlast;
                        err_d   = s_udp_payload_axis_tlast & s_udp_payload_axis_tuser;
                        asm_d   = '0;
                        k_d     = '0;
                    end else begin
                        asm_d = word_c;
                        k_d   = K_W'(k_q + K_W'(1));
                    end
                    if (s_udp_payload_axis_tlast) begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                tready_c = 1'b1;
                if (s_udp_payload_axis_tvalid && s_udp_payload_axis_tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rstn) begin
            state_q <= IDLE;
            asm_q   <= '0;
            k_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            asm_q   <= asm_d;
            k_q     <= k_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    // Handshake readies are forced low while reset is held
    assign s_udp_hdr_ready           = sys_rstn & hdr_ready_c;
    assign s_udp_payload_axis_tready = sys_rstn & tready_c;
    assign dout_data                 = data_q;
    assign dout_valid                = valid_q;
    assign dout_last                 = last_q;
    assign dout_err                  = err_q;

`ifdef UDP_RX_STATS_EN
    logic [15:0] frame_q;
    logic [15:0] drop_q;

    always_ff @(posedge sys_clk) begin
        if (!sys_rstn) begin
            frame_q <= '0;
            drop_q  <= '0;
        end else begin
            if (valid_q && dout_ready && last_q) begin
                frame_q <= 16'(frame_q + 16'd1);
            end
            if ((state_q == DROP) && s_udp_payload_axis_tvalid && s_udp_payload_axis_tlast) begin
                drop_q <= 16'(drop_q + 16'd1);
            end
        end
    end

    assign frame_cnt = frame_q;
    assign drop_cnt  = drop_q;
`endif

endmodule
